// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the multicycle RV32I core. It sequences the
//            shared ALU, the unified memory port, the PC and the register file.
// Option   : MC_INSTRET_EN adds a 32-bit retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

// These fallbacks apply only when define.v has not already been included.
`ifndef ALUOP_LOAD_STORE
`define ALUOP_LOAD_STORE 3'b000
`endif
`ifndef ALUOP_BRANCH
`define ALUOP_BRANCH 3'b001
`endif
`ifndef ALUOP_RTYPE
`define ALUOP_RTYPE 3'b010
`endif
`ifndef ALUOP_ITYPE
`define ALUOP_ITYPE 3'b011
`endif

module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_R     = 7'b0110011;
  localparam logic [6:0] C_OP_I     = 7'b0010011;
  localparam logic [6:0] C_OP_BR    = 7'b1100011;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;
  localparam logic [6:0] C_OP_JALR  = 7'b1100111;
  localparam logic [6:0] C_OP_LUI   = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JUMP     = 4'd11,
    S_UTYPE    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    alu_op     = `ALUOP_LOAD_STORE;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (op)
          C_OP_LOAD, C_OP_STORE: w_next = S_MEMADR;
          C_OP_R:                w_next = S_EXEC_R;
          C_OP_I:                w_next = S_EXEC_I;
          C_OP_BR:               w_next = S_BRANCH;
          C_OP_JAL:              w_next = S_JUMP;
          C_OP_JALR:             w_next = S_JALR;
          C_OP_LUI, C_OP_AUIPC:  w_next = S_UTYPE;
          default:               w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        // Loads and stores differ only in opcode bit 5.
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_op    = `ALUOP_RTYPE;
        w_next    = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op    = `ALUOP_ITYPE;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_op    = `ALUOP_BRANCH;
        pc_write  = br_cond;
        w_next    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        w_next    = S_JUMP;
      end
      S_JUMP: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_UTYPE: begin
        alu_src_a = (op == C_OP_LUI) ? 2'd3 : 2'd1;
        alu_src_b = 2'd1;
        w_next    = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    // Reset abandons the current instruction without any stray write.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;

`ifdef MC_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (rst)           r_instret <= 32'h0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the PC and the register file over several cycles per instruction. It drives `alu_op` into ALU_Decoder using the `ALUOP_*` codes from define.v, and it stalls on a memory ready handshake. It sits between the instruction register's opcode field and the datapath select/enable lines.

## Interface
Parameters: none. All opcode and ALUOp encodings come from define.v.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode field, taken from the IR (valid from DECODE onward)
- br_cond  in  1  branch condition for the current funct3, computed by the datapath from the ALU result
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- ir_write  out  1  IR and oldPC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_req  out  1  memory access request
- mem_write  out  1  access is a store (only valid with mem_req)
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = oldPC, 2 = rs1, 3 = zero
- alu_src_b  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = constant 4
- result_src  out  2  result select: 0 = ALUOut, 1 = memory read data, 2 = ALU result
- alu_op  out  3  ALUOp code sent to ALU_Decoder
- illegal  out  1  unsupported opcode trapped (sticky until reset)
- state  out  4  current state, for debug
- instret  out  32  retired-instruction count (see Configuration)

## Operation
- Outputs are Moore-decoded from `state`, except where noted. Any output not listed for a state is 0. `alu_op` defaults to `ALUOP_LOAD_STORE`.
- States and encodings, with their actions and next state:
  - FETCH (0): adr_src=0, mem_req=1, alu_src_a=0, alu_src_b=2, result_src=2. pc_write and ir_write are both equal to mem_ready. Hold while mem_ready=0; otherwise go to DECODE.
  - DECODE (1): alu_src_a=1, alu_src_b=1, so ALUOut receives the branch/JAL target. Next state by op:
    - load 0000011 or store 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JUMP
    - 1100111 → JALR
    - 0110111 or 0010111 → UTYPE
    - any other op → TRAP
  - MEMADR (2): alu_src_a=2, alu_src_b=1. Go to MEMREAD if op is a load, MEMWRITE if op is a store.
  - MEMREAD (3): adr_src=1, mem_req=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB (4): result_src=1, reg_write=1. Go to FETCH.
  - MEMWRITE (5): adr_src=1, mem_req=1, mem_write=1. Hold until mem_ready, then go to FETCH.
  - EXEC_R (6): alu_src_a=2, alu_src_b=0, alu_op=`ALUOP_RTYPE`. Go to ALUWB.
  - EXEC_I (7): alu_src_a=2, alu_src_b=1, alu_op=`ALUOP_ITYPE`. Go to ALUWB.
  - ALUWB (8): result_src=0, reg_write=1. Go to FETCH.
  - BRANCH (9): alu_src_a=2, alu_src_b=0, alu_op=`ALUOP_BRANCH`, result_src=0, pc_write=br_cond (Mealy). Go to FETCH.
  - JALR (10): alu_src_a=2, alu_src_b=1, so ALUOut receives rs1+imm. Go to JUMP.
  - JUMP (11): alu_src_a=1, alu_src_b=2, result_src=0, pc_write=1. The PC loads the target held in ALUOut, and ALUOut receives oldPC+4. Go to ALUWB.
  - UTYPE (12): alu_src_b=1. alu_src_a=3 for lui, 1 for auipc. Go to ALUWB.
  - TRAP (13): every enable is 0, illegal=1. The FSM stays in TRAP until rst.
- Encodings 14–15 are unreachable; if entered, the next state is FETCH.

## Timing
- Reset:
  - rst=1 at a rising edge sets state=FETCH and clears illegal; instret also clears when enabled.
  - While rst=1, pc_write, ir_write, reg_write, mem_req and mem_write are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no partial write is issued after the reset edge.
- Cycles per instruction with mem_ready held at 1:
  - load 5, jalr 5
  - store 4, R 4, I 4, jal 4, lui/auipc 4
  - branch 3
- Each cycle that mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. During that stall mem_req, adr_src and mem_write stay stable.
- mem_ready is ignored in every state that is not waiting on memory.

## Configuration
- `MC_INSTRET_EN` defined: instret is a 32-bit counter that increments by 1 on each edge that leaves a retiring state toward FETCH:
  - MEMWB
  - MEMWRITE with mem_ready=1
  - ALUWB
  - BRANCH
- The counter wraps from 0xFFFFFFFF to 0. TRAP never counts.
- `MC_INSTRET_EN` undefined: instret is tied to 32'h0 and no counter flops exist.

## Test plan
- Reset with op=0110011 and mem_ready=1: the sequence is FETCH→DECODE→EXEC_R→ALUWB→FETCH. alu_op=`ALUOP_RTYPE` in EXEC_R, reg_write=1 only in ALUWB, and instret=1.
- Load with mem_ready low for 2 cycles in MEMREAD: 7 cycles total. mem_req=1 and adr_src=1 are held throughout the stall. reg_write pulses once, in MEMWB.
- Branch (op=1100011) with br_cond=1, then with br_cond=0: pc_write=1 in BRANCH for the first and 0 for the second. alu_op=`ALUOP_BRANCH` in both cases, and both take 3 cycles.
- jalr: state order FETCH→DECODE→JALR→JUMP→ALUWB. pc_write=1 in FETCH and JUMP; reg_write=1 in ALUWB.
- op=0000000: TRAP is entered after DECODE, illegal=1, and there are no enables for 10 cycles. rst for one cycle then gives state=0 and illegal=0.
- With `MC_INSTRET_EN`: preload via 2^32−1 retirements in a forced sim, or a counter with a shortened width; the next retirement gives instret=0.
